// File: rtl/ycfsm_array_pkg.sv
// Shared dual-rail codes and lane state encoding for the ycfsm lane array.
package ycfsm_array_pkg;

  localparam logic [1:0] DR_EMPTY = 2'b00;
  localparam logic [1:0] DR_ZERO  = 2'b01;
  localparam logic [1:0] DR_ONE   = 2'b10;
  localparam logic [1:0] DR_ILL   = 2'b11;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_ERROR = 2'd2
  } lane_state_e;

endpackage

// File: rtl/ycfsm_array_lane.sv
// One dual-rail cell FSM: latches a matching token, holds it until return-to-empty,
// and sticks in ERROR on any protocol violation.
module ycfsm_lane
  import ycfsm_array_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] in,
  input  logic [1:0] match,
  output logic [1:0] out,
  output logic       err,
  output logic       full,
  output logic       accept
);

  lane_state_e state_reg, state_next;
  logic [1:0]  value_reg, value_next;

  always_comb begin
    state_next = state_reg;
    value_next = value_reg;
    accept     = 1'b0;
    if (in == DR_ILL) begin
      state_next = S_ERROR;
    end else begin
      case (state_reg)
        S_EMPTY: begin
          // A blocked token simply waits; match is re-sampled every cycle here.
          if (in != DR_EMPTY && (in & match) != DR_EMPTY) begin
            state_next = S_FULL;
            value_next = in & match;
            accept     = 1'b1;
          end
        end
        S_FULL: begin
          if (in == DR_EMPTY)
            state_next = S_EMPTY;
          else if (in != value_reg)
            state_next = S_ERROR;
        end
        default: state_next = S_ERROR;
      endcase
    end
  end

  // Next-state view so the top can register all_full in step with out.
  assign full = (state_next == S_FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_EMPTY;
      value_reg <= DR_EMPTY;
      out       <= DR_EMPTY;
      err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      value_reg <= value_next;
      out       <= (state_next == S_FULL) ? value_next : DR_EMPTY;
      err       <= (state_next == S_ERROR);
    end
  end

endmodule

// File: rtl/ycfsm_array.sv
// Array of independent dual-rail lane FSMs with a shared saturating accept counter
// and a registered all-lanes-full flag.
module ycfsm_array
  import ycfsm_array_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*LANES-1:0] in,
  input  logic [2*LANES-1:0] match,
  output logic [2*LANES-1:0] out,
  output logic [LANES-1:0]   err,
  output logic               all_full,
  output logic [CNT_W-1:0]   token_count
);

  localparam int SUM_W = CNT_W + $clog2(LANES + 1);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [LANES-1:0] full_next;
  logic [LANES-1:0] accept;
  logic [SUM_W-1:0] accept_cnt;
  logic [SUM_W-1:0] sum_next;
  logic [CNT_W-1:0] token_count_reg, token_count_next;
  logic             all_full_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      ycfsm_lane u_lane (
        .clk    (clk),
        .reset  (reset),
        .in     (in[2*gi+1:2*gi]),
        .match  (match[2*gi+1:2*gi]),
        .out    (out[2*gi+1:2*gi]),
        .err    (err[gi]),
        .full   (full_next[gi]),
        .accept (accept[gi])
      );
    end
  endgenerate

  always_comb begin
    accept_cnt = '0;
    for (int i = 0; i < LANES; i++)
      accept_cnt = accept_cnt + SUM_W'(accept[i]);
  end

  // Extra headroom bits let the sum exceed the counter range before clamping.
  assign sum_next         = SUM_W'(token_count_reg) + accept_cnt;
  assign token_count_next = (sum_next > CNT_MAX) ? {CNT_W{1'b1}} : sum_next[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      token_count_reg <= '0;
      all_full_reg    <= 1'b0;
    end else begin
      token_count_reg <= token_count_next;
      all_full_reg    <= &full_next;
    end
  end

  assign token_count = token_count_reg;
  assign all_full    = all_full_reg;

endmodule
